// File: rtl/pulse_sched_pkg.sv
// Shared types and elaboration helpers for the pulse scheduler.
// Holds the controller state encoding and the phase-counter width check.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COOLDOWN
    } state_e;

    // True when a counter of cnt_w bits can represent the longer of the two phases.
    function automatic bit cnt_w_fits(int cnt_w, int act_cyc, int off_cyc);
        int max_v;
        max_v = (act_cyc > off_cyc) ? act_cyc : off_cyc;
        return max_v < (1 << cnt_w);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts just above i_last_grant,
// ascends and wraps; requests whose i_mask bit is set are ignored.
module rr_arbiter
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int LG_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_mask,
    input  logic [LG_W-1:0]  i_last_grant,
    input  logic             i_enable,
    output logic [N_REQ-1:0] o_winner
);

    logic [N_REQ-1:0] w_eligible;
    logic [LG_W:0]    w_shift;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_rot_win;
    logic [N_REQ-1:0] w_win;

    assign w_eligible = i_req & ~i_mask;
    assign w_shift    = {1'b0, i_last_grant} + {{LG_W{1'b0}}, 1'b1};

    // Rotate so bit 0 is the highest-priority index, take the lowest set bit,
    // then rotate the one-hot result back into requester order.
    assign w_rot     = N_REQ'({w_eligible, w_eligible} >> w_shift);
    assign w_rot_win = w_rot & (~w_rot + N_REQ'(1));
    assign w_win     = N_REQ'(({w_rot_win, w_rot_win} << w_shift) >> N_REQ);

    assign o_winner = i_enable ? w_win : '0;

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one pulse engine among N_REQ requesters: each grant runs ACT_CYC
// active cycles then OFF_CYC cooldown cycles, with round-robin hand-over.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ACT_CYC = 3,
    parameter int OFF_CYC = 2,
    parameter int CNT_W   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic             Y_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int LG_W = $clog2(N_REQ);

    generate
        if (!cnt_w_fits(CNT_W, ACT_CYC, OFF_CYC)) begin : g_cnt_w_check
            $error("pulse_scheduler: CNT_W too narrow for ACT_CYC/OFF_CYC");
        end
    endgenerate

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [LG_W-1:0]  r_last, w_last_nxt;
    logic [N_REQ-1:0] w_winner;
    logic [N_REQ-1:0] w_mask;
    logic [LG_W-1:0]  w_win_idx;
    logic             w_act_last;
    logic             w_cool_last;
    logic             w_arb_en;

    assign w_act_last  = (r_state == ACTIVE)   && (r_cnt == CNT_W'(ACT_CYC - 1));
    assign w_cool_last = (r_state == COOLDOWN) && (r_cnt == CNT_W'(OFF_CYC - 1));

    // Hand-over on the final cooldown edge excludes the current owner, so a
    // lone requester sees one IDLE cycle before it can win again.
    assign w_arb_en = (r_state == IDLE) || w_cool_last;
    assign w_mask   = (r_state == COOLDOWN) ? r_gnt : '0;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arbiter (
        .i_req        (REQ),
        .i_mask       (w_mask),
        .i_last_grant (r_last),
        .i_enable     (w_arb_en),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner[i]) w_win_idx = LG_W'(i);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (|w_winner) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = w_winner;
                    w_last_nxt  = w_win_idx;
                end
            end
            ACTIVE: begin
                if (w_act_last) begin
                    w_state_nxt = COOLDOWN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            COOLDOWN: begin
                if (w_cool_last) begin
                    w_cnt_nxt = '0;
                    if (|w_winner) begin
                        w_state_nxt = ACTIVE;
                        w_gnt_nxt   = w_winner;
                        w_last_nxt  = w_win_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_last  <= LG_W'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign GNT   = r_gnt;
    assign Y_OUT = (r_state == ACTIVE);
    assign BUSY  = (r_state != IDLE);
    assign DONE  = w_cool_last;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench: two scheduler instances (3+2 and 1+1 phases) driven with
// directed and random requests, compared against a burst-countdown model.
module tb_pulse_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_a, rst_b;
    logic [N-1:0] req_a, req_b;
    logic [N-1:0] gnt_a, gnt_b;
    logic         y_a, busy_a, done_a;
    logic         y_b, busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: cycles left in the current burst, its owner, and the pointer.
    int m_left [2];
    int m_owner[2];
    int m_last [2];
    int m_act  [2] = '{3, 1};
    int m_off  [2] = '{2, 1};

    always #5 clk = ~clk;

    pulse_scheduler #(
        .N_REQ(N), .ACT_CYC(3), .OFF_CYC(2), .CNT_W(4)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .REQ(req_a), .GNT(gnt_a),
        .Y_OUT(y_a), .BUSY(busy_a), .DONE(done_a)
    );

    pulse_scheduler #(
        .N_REQ(N), .ACT_CYC(1), .OFF_CYC(1), .CNT_W(4)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .REQ(req_b), .GNT(gnt_b),
        .Y_OUT(y_b), .BUSY(busy_b), .DONE(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int mask_idx, input int last);
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (last + i) % N;
            if (req[idx] && idx != mask_idx) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic rst, input logic [N-1:0] req);
        int p;
        if (rst) begin
            m_left[d]  = 0;
            m_owner[d] = -1;
            m_last[d]  = N - 1;
        end else if (m_left[d] > 1) begin
            m_left[d]--;
        end else begin
            p = rr_pick(req, (m_left[d] == 1) ? m_owner[d] : -1, m_last[d]);
            if (p >= 0) begin
                m_left[d]  = m_act[d] + m_off[d];
                m_owner[d] = p;
                m_last[d]  = p;
            end else begin
                m_left[d]  = 0;
                m_owner[d] = -1;
            end
        end
    endtask

    task automatic compare(input int d, input logic [N-1:0] gnt, input logic y,
                           input logic busy, input logic done);
        string       p;
        logic [31:0] exp_g;
        p     = (d == 0) ? "A" : "B";
        exp_g = (m_left[d] > 0) ? (32'd1 << m_owner[d]) : 32'd0;
        check({p, ".gnt"},    gnt,  exp_g);
        check({p, ".y"},      y,    m_left[d] > m_off[d]);
        check({p, ".busy"},   busy, m_left[d] > 0);
        check({p, ".done"},   done, m_left[d] == 1);
        check({p, ".onehot"}, $onehot0(gnt), 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, rst_a, req_a);
        model_step(1, rst_b, req_b);
        @(negedge clk);
        compare(0, gnt_a, y_a, busy_a, done_a);
        compare(1, gnt_b, y_b, busy_b, done_b);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = '0;
        req_b = '0;
        for (int d = 0; d < 2; d++) begin
            m_left[d]  = 0;
            m_owner[d] = -1;
            m_last[d]  = N - 1;
        end
        @(negedge clk);
        cycle();
        cycle();
        check("A.reset_gnt", gnt_a, 0);
        rst_a = 1'b0;

        // Single request, dropped during the burst.
        req_a = 4'b0001;
        cycle();
        check("A.first_gnt", gnt_a, 4'b0001);
        req_a = '0;
        repeat (7) cycle();

        // All requesting after reset: back-to-back round robin on A;
        // B with 1+1 phases alternates between its two requesters.
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0;
        req_a = 4'b1111;
        rst_b = 1'b0;
        req_b = 4'b0011;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            check("A.rr_gnt",  gnt_a,  32'd1 << (((k - 1) / 5) % 4));
            check("A.rr_y",    y_a,    ((k - 1) % 5) < 3);
            check("A.rr_busy", busy_a, 1);
            if (k <= 8) begin
                check("B.alt_y",   y_b,   k % 2);
                check("B.alt_gnt", gnt_b, (((k - 1) / 2) % 2) != 0 ? 2 : 1);
            end
        end
        req_a = '0;
        repeat (6) cycle();

        // Lone requester held past DONE: one IDLE cycle, then re-grant.
        req_a = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (k == 5) check("A.hold_done", done_a, 1);
            if (k == 6) check("A.hold_idle", busy_a, 0);
            if (k == 7) check("A.hold_regnt", gnt_a, 4'b0001);
        end
        req_a = '0;
        repeat (6) cycle();

        // One-cycle request pulse still gets the full burst.
        req_a = 4'b0100;
        cycle();
        check("A.pulse_gnt", gnt_a, 4'b0100);
        req_a = '0;
        repeat (4) begin
            cycle();
            check("A.pulse_hold", gnt_a, 4'b0100);
        end
        cycle();
        check("A.pulse_end", busy_a, 0);

        // Reset in the second ACTIVE cycle, then pointer restarts at 0.
        req_a = 4'b0001;
        cycle();
        cycle();
        rst_a = 1'b1;
        req_a = '0;
        cycle();
        check("A.rst_y",    y_a,    0);
        check("A.rst_busy", busy_a, 0);
        rst_a = 1'b0;
        req_a = 4'b1010;
        cycle();
        check("A.ptr_reset", gnt_a, 4'b0010);
        req_a = '0;
        repeat (6) cycle();

        // Random traffic with occasional resets on both instances.
        for (int i = 0; i < 3000; i++) begin
            req_a = N'($urandom);
            req_b = N'($urandom);
            rst_a = ($urandom_range(0, 99) == 0);
            rst_b = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Shares one pulse engine (output active `ACT_CYC` cycles, then forced inactive `OFF_CYC` cycles) among `N_REQ` requesters. A round-robin arbiter selects the requester, and a three-state controller sequences active and cooldown phases. The block sits between request sources and the downstream pulse-driven load. It replaces per-source ad hoc FSMs with one scheduled resource.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `ACT_CYC`, 3: active-phase length in cycles, >=1
- `OFF_CYC`, 2: cooldown length in cycles, >=1
- `CNT_W`, 4: phase counter width; must hold max(`ACT_CYC`,`OFF_CYC`)
- `CLK`  in  1  clock, all logic on posedge
- `RST`  in  1  reset, synchronous, active-high
- `REQ`  in  `N_REQ`  level requests; requester holds until its `DONE`
- `GNT`  out  `N_REQ`  one-hot grant, held through ACTIVE and COOLDOWN
- `Y_OUT`  out  1  pulse to load, high only in ACTIVE
- `BUSY`  out  1  high in ACTIVE or COOLDOWN
- `DONE`  out  1  one-cycle strobe on last COOLDOWN cycle

## Operation
- States:
  - IDLE: all outputs 0.
  - ACTIVE: `Y_OUT`=1, counter counts `ACT_CYC` cycles.
  - COOLDOWN: `Y_OUT`=0, counter counts `OFF_CYC` cycles.
- IDLE -> ACTIVE: on the edge where `|REQ`=1. The arbiter winner is registered into `GNT` on that same edge.
- ACTIVE -> COOLDOWN: after exactly `ACT_CYC` cycles in ACTIVE.
- COOLDOWN -> next state: after exactly `OFF_CYC` cycles, with `DONE`=1 in the final cycle.
  - On that edge the block re-arbitrates with the current grantee's bit masked.
  - If any unmasked request is present, it goes straight to ACTIVE with the new `GNT`; no IDLE bubble.
  - Otherwise it goes to IDLE.
- Round-robin:
  - The search starts at index (last_grant+1) mod `N_REQ` and ascends.
  - After reset, last_grant = `N_REQ`-1, so `REQ[0]` has top priority.
  - The pointer updates only when a grant is issued.
- Same requester twice: it can regain the resource only after one IDLE cycle. Its `REQ` is masked on the `DONE` edge, so it must re-request.
- `REQ` deassertion during ACTIVE or COOLDOWN is ignored; the burst always completes. Nothing is aborted.
- `GNT` is always one-hot or zero. `Y_OUT`=1 implies `BUSY`=1 and `GNT`!=0.

## Timing
- Reset, including mid-operation: the state goes to IDLE on the edge where `RST`=1. Reset values:
  - `GNT`=0, `Y_OUT`=0, `BUSY`=0, `DONE`=0
  - counter=0, last_grant=`N_REQ`-1
- All outputs are registered; there is no combinational path from `REQ` to any output.
- Latency: `REQ` high before edge t gives `GNT`, `Y_OUT` and `BUSY` high in the cycle after t.
- Burst length: `ACT_CYC`+`OFF_CYC` cycles of `BUSY`.
- Back-to-back bursts to different requesters: `BUSY` stays continuously high and `Y_OUT` has exactly `OFF_CYC` low cycles between pulses.
- `RST` has priority over every transition.

## Structure
- Package `pulse_sched_pkg`: state enum {IDLE, ACTIVE, COOLDOWN}, and a function for the `CNT_W` minimum-width check.
- Sub-module `rr_arbiter`:
  - Parameter: `N_REQ`.
  - Inputs: requests, mask, last_grant, enable.
  - Output: combinational one-hot winner.
- Top level: FSM, phase counter, `GNT` and last_grant registers.

## Test plan
Defaults, 10 ns clock.
- Reset then `REQ`=0001 -> `GNT`=0001 next cycle; `Y_OUT` high 3 cycles then low 2; `DONE` on cycle 5; then IDLE.
- `REQ`=1111 held throughout -> grants 0001, 0010, 0100, 1000, 0001 back-to-back; `BUSY` continuously 1; `Y_OUT` pattern 11100 repeated.
- `REQ`=0001 only, held past `DONE` -> after `DONE`, 1 IDLE cycle, then re-grant 0001.
- `REQ[2]` pulsed for 1 cycle in IDLE -> full 3+2 burst on `GNT`=0100 despite the early drop.
- `RST`=1 asserted in the 2nd ACTIVE cycle -> next cycle all outputs 0. After release with `REQ`=1010, `GNT`=0010 (pointer reset).
- Parameters `ACT_CYC`=1, `OFF_CYC`=1 with `REQ`=0011 -> `Y_OUT` alternates 1,0; `GNT` alternates 0001, 0010.
